// File: rtl/axi_dac_jesd204_tx_sequencer.sv
// DAC sample sequencer feeding the JESD204 TX framer: link/settle gating, DMA/ramp/zero sourcing,
// per-channel masking and sticky status. Optional macro DAC_TX_SEQ_UNDERFLOW_CNT_EN adds a saturating underflow counter.
module axi_dac_jesd204_tx_sequencer #(
    parameter int NUM_LANES     = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                      tx_clk,
    input  logic                      dac_rstn,
    input  logic                      dac_enable,
    input  logic [1:0]                dac_mode,
    input  logic [NUM_CHANNELS-1:0]   chan_enable,
    input  logic                      link_ready,
    input  logic [NUM_LANES*32-1:0]   s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [NUM_LANES*32-1:0]   dac_data,
    output logic                      dac_running,
    output logic                      status_underflow,
    output logic                      status_link_lost,
    input  logic                      status_clear,
    output logic [15:0]               underflow_count
);

    localparam int W   = NUM_LANES * 32;
    localparam int DPW = 2 * NUM_LANES / NUM_CHANNELS;
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] RAMP_STEP   = 16'(DPW);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINK = 2'd1,
        ST_SETTLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [15:0]   settle_cnt_r;
    logic [15:0]   ramp_base_r;
    logic [W-1:0]  dac_data_r;
    logic          underflow_r;
    logic          link_lost_r;

    logic          run_s;
    logic          accept_s;
    logic          underflow_s;
    logic          link_drop_s;
    logic          run_entry_s;
    logic          settle_load_s;
    logic [W-1:0]  ramp_s;
    logic [W-1:0]  raw_s;
    logic [W-1:0]  data_nxt_s;

    // State register
    always_ff @(posedge tx_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; dropping dac_enable outranks every link event
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dac_enable) begin
                    state_nxt_s = ST_WAIT_LINK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_LINK: begin
                if (!dac_enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (link_ready) begin
                    state_nxt_s = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;
                end else begin
                    state_nxt_s = ST_WAIT_LINK;
                end
            end
            ST_SETTLE: begin
                if (!dac_enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (!link_ready) begin
                    state_nxt_s = ST_WAIT_LINK;
                end else if (settle_cnt_r == 16'd0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_RUN: begin
                if (!dac_enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (!link_ready) begin
                    state_nxt_s = ST_WAIT_LINK;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State-derived controls; s_ready depends only on registered state and dac_mode, never on s_valid
    always_comb begin
        run_s         = (state_r == ST_RUN);
        dac_running   = run_s;
        s_ready       = run_s && (dac_mode == 2'd1);
        accept_s      = s_ready && s_valid;
        underflow_s   = s_ready && !s_valid;
        link_drop_s   = run_s && dac_enable && !link_ready;
        run_entry_s   = (state_r != ST_RUN) && (state_nxt_s == ST_RUN);
        settle_load_s = (state_r == ST_WAIT_LINK) && (state_nxt_s == ST_SETTLE);
    end

    // Settle countdown
    always_ff @(posedge tx_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            settle_cnt_r <= 16'd0;
        end else if (settle_load_s) begin
            settle_cnt_r <= SETTLE_LOAD;
        end else if ((state_r == ST_SETTLE) && (settle_cnt_r != 16'd0)) begin
            settle_cnt_r <= settle_cnt_r - 16'd1;
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // Ramp base advances every RUN cycle regardless of mode and restarts on each RUN entry
    always_ff @(posedge tx_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            ramp_base_r <= 16'd0;
        end else if (run_entry_s) begin
            ramp_base_r <= 16'd0;
        end else if (run_s) begin
            ramp_base_r <= ramp_base_r + RAMP_STEP;
        end else begin
            ramp_base_r <= ramp_base_r;
        end
    end

    // Ramp pattern: sample j of every channel is base + j
    always_comb begin
        ramp_s = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            for (int j = 0; j < DPW; j++) begin
                ramp_s[(i*DPW+j)*16 +: 16] = ramp_base_r + 16'(j);
            end
        end
    end

    // Source select; anything other than an accepted beat or the ramp yields zeros
    always_comb begin
        raw_s = '0;
        if (run_s) begin
            case (dac_mode)
                2'd1: begin
                    if (accept_s) begin
                        raw_s = s_data;
                    end else begin
                        raw_s = '0;
                    end
                end
                2'd2:    raw_s = ramp_s;
                default: raw_s = '0;
            endcase
        end else begin
            raw_s = '0;
        end
    end

    // Per-channel mask
    always_comb begin
        data_nxt_s = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            for (int j = 0; j < DPW; j++) begin
                data_nxt_s[(i*DPW+j)*16 +: 16] =
                    chan_enable[i] ? raw_s[(i*DPW+j)*16 +: 16] : 16'd0;
            end
        end
    end

    // Output sample register
    always_ff @(posedge tx_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            dac_data_r <= '0;
        end else begin
            dac_data_r <= data_nxt_s;
        end
    end

    assign dac_data = dac_data_r;

    // Sticky status flags; a set in the same cycle as clear wins
    always_ff @(posedge tx_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            underflow_r <= 1'b0;
            link_lost_r <= 1'b0;
        end else begin
            if (underflow_s) begin
                underflow_r <= 1'b1;
            end else if (status_clear) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
            if (link_drop_s) begin
                link_lost_r <= 1'b1;
            end else if (status_clear) begin
                link_lost_r <= 1'b0;
            end else begin
                link_lost_r <= link_lost_r;
            end
        end
    end

    assign status_underflow = underflow_r;
    assign status_link_lost = link_lost_r;

`ifdef DAC_TX_SEQ_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt_r;

    // Saturating underflow counter; clear with a coincident underflow restarts at one
    always_ff @(posedge tx_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            underflow_cnt_r <= 16'd0;
        end else if (underflow_s && status_clear) begin
            underflow_cnt_r <= 16'd1;
        end else if (underflow_s) begin
            if (underflow_cnt_r != 16'hFFFF) begin
                underflow_cnt_r <= underflow_cnt_r + 16'd1;
            end else begin
                underflow_cnt_r <= underflow_cnt_r;
            end
        end else if (status_clear) begin
            underflow_cnt_r <= 16'd0;
        end else begin
            underflow_cnt_r <= underflow_cnt_r;
        end
    end

    assign underflow_count = underflow_cnt_r;
`else
    assign underflow_count = 16'd0;
`endif

endmodule

// File: tb/tb_axi_dac_jesd204_tx_sequencer.sv
// Self-checking bench: randomized stimulus compared every cycle against a streak-counting behavioural model.
module tb_axi_dac_jesd204_tx_sequencer;

    localparam int NUM_LANES     = 8;
    localparam int NUM_CHANNELS  = 4;
    localparam int SETTLE_CYCLES = 16;
    localparam int W             = NUM_LANES * 32;
    localparam int DPW           = 2 * NUM_LANES / NUM_CHANNELS;
    localparam int NSAMP         = 2 * NUM_LANES;

    logic                    tx_clk = 1'b0;
    logic                    dac_rstn;
    logic                    dac_enable;
    logic [1:0]              dac_mode;
    logic [NUM_CHANNELS-1:0] chan_enable;
    logic                    link_ready;
    logic [W-1:0]            s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic [W-1:0]            dac_data;
    logic                    dac_running;
    logic                    status_underflow;
    logic                    status_link_lost;
    logic                    status_clear;
    logic [15:0]             underflow_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Behavioural model state
    bit           m_active;
    bit           m_running;
    int           m_streak;
    int           m_ramp_beats;
    bit           m_uf;
    bit           m_ll;
    int           m_cnt;
    logic [W-1:0] m_data;

    always #5 tx_clk = ~tx_clk;

    axi_dac_jesd204_tx_sequencer #(
        .NUM_LANES(NUM_LANES), .NUM_CHANNELS(NUM_CHANNELS), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .tx_clk(tx_clk), .dac_rstn(dac_rstn), .dac_enable(dac_enable), .dac_mode(dac_mode),
        .chan_enable(chan_enable), .link_ready(link_ready), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .dac_data(dac_data), .dac_running(dac_running),
        .status_underflow(status_underflow), .status_link_lost(status_link_lost),
        .status_clear(status_clear), .underflow_count(underflow_count)
    );

    function automatic logic [15:0] exp_count();
`ifdef DAC_TX_SEQ_UNDERFLOW_CNT_EN
        return 16'(m_cnt);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        for (int k = 0; k < W / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_running = 1'b0; m_streak = 0; m_ramp_beats = 0;
        m_uf = 1'b0; m_ll = 1'b0; m_cnt = 0; m_data = '0;
    endtask

    // One clock: predict from the applied inputs, advance, and compare every output
    task automatic cycle();
        logic [W-1:0] raw;
        bit uf_set, ll_set;
        #1;
        vectors++;
        if (s_ready !== (m_running && dac_mode == 2'd1)) begin
            miscompares++;
            $display("FAIL s_ready cyc=%0d got %b expected %b", cyc, s_ready, m_running && dac_mode == 2'd1);
        end
        raw = '0;
        uf_set = 1'b0;
        if (m_running) begin
            if (dac_mode == 2'd1) begin
                if (s_valid) raw = s_data;
                else uf_set = 1'b1;
            end else if (dac_mode == 2'd2) begin
                for (int k = 0; k < NSAMP; k++)
                    raw[k*16 +: 16] = 16'((m_ramp_beats * DPW + (k % DPW)) % 65536);
            end
            m_ramp_beats++;
        end
        for (int k = 0; k < NSAMP; k++)
            if (!chan_enable[k / DPW]) raw[k*16 +: 16] = 16'd0;
        m_data = raw;
        ll_set = m_running && dac_enable && !link_ready;
        m_uf = uf_set ? 1'b1 : (status_clear ? 1'b0 : m_uf);
        m_ll = ll_set ? 1'b1 : (status_clear ? 1'b0 : m_ll);
        if (uf_set && status_clear) m_cnt = 1;
        else if (uf_set) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        else if (status_clear) m_cnt = 0;
        // Running after SETTLE_CYCLES+1 consecutive linked edges once enabled
        if (!dac_enable) begin
            m_active = 1'b0; m_running = 1'b0; m_streak = 0;
        end else if (!m_active) begin
            m_active = 1'b1; m_streak = 0;
        end else if (m_running) begin
            if (!link_ready) begin m_running = 1'b0; m_streak = 0; end
        end else if (link_ready) begin
            m_streak++;
            if (m_streak == SETTLE_CYCLES + 1) begin m_running = 1'b1; m_ramp_beats = 0; m_streak = 0; end
        end else begin
            m_streak = 0;
        end
        @(posedge tx_clk);
        #1;
        cyc++;
        vectors += 5;
        if (dac_data !== m_data) begin
            miscompares++; $display("FAIL dac_data cyc=%0d got %h expected %h", cyc, dac_data, m_data);
        end
        if (dac_running !== m_running) begin
            miscompares++; $display("FAIL dac_running cyc=%0d got %b expected %b", cyc, dac_running, m_running);
        end
        if (status_underflow !== m_uf) begin
            miscompares++; $display("FAIL status_underflow cyc=%0d got %b expected %b", cyc, status_underflow, m_uf);
        end
        if (status_link_lost !== m_ll) begin
            miscompares++; $display("FAIL status_link_lost cyc=%0d got %b expected %b", cyc, status_link_lost, m_ll);
        end
        if (underflow_count !== exp_count()) begin
            miscompares++; $display("FAIL underflow_count cyc=%0d got %0d expected %0d", cyc, underflow_count, exp_count());
        end
    endtask

    task automatic wait_running(input string tag, output int waited);
        waited = 0;
        while (!dac_running && waited < 60) begin
            cycle();
            waited++;
        end
        vectors++;
        if (!dac_running) begin
            miscompares++; $display("FAIL %s timeout got running=%b expected 1", tag, dac_running);
        end
    endtask

    task automatic idle_inputs();
        dac_enable = 1'b0; dac_mode = 2'd0; chan_enable = '1; link_ready = 1'b0;
        s_data = '0; s_valid = 1'b0; status_clear = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge tx_clk);
        dac_rstn = 1'b1;
        @(posedge tx_clk);
        #1;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        dac_rstn = 1'b0;
        #23;
        vectors += 6;
        if (dac_data !== '0)            begin miscompares++; $display("FAIL reset_data got %h expected 0", dac_data); end
        if (s_ready !== 1'b0)           begin miscompares++; $display("FAIL reset_s_ready got %b expected 0", s_ready); end
        if (dac_running !== 1'b0)       begin miscompares++; $display("FAIL reset_running got %b expected 0", dac_running); end
        if (status_underflow !== 1'b0)  begin miscompares++; $display("FAIL reset_uf got %b expected 0", status_underflow); end
        if (status_link_lost !== 1'b0)  begin miscompares++; $display("FAIL reset_ll got %b expected 0", status_link_lost); end
        if (underflow_count !== 16'd0)  begin miscompares++; $display("FAIL reset_cnt got %0d expected 0", underflow_count); end
        release_reset();
    endtask

    task automatic test_startup();
        int rise = -1;
        dac_enable = 1'b1;
        for (int c = 0; c < 30; c++) begin
            link_ready = (c >= 5);
            cycle();
            if (dac_running && rise < 0) rise = cyc;
        end
        vectors++;
        if (rise != 5 + SETTLE_CYCLES + 1) begin
            miscompares++; $display("FAIL startup_rise got cycle %0d expected %0d", rise, 5 + SETTLE_CYCLES + 1);
        end
    endtask

    task automatic test_dma_mask();
        dac_mode = 2'd1; chan_enable = 4'b1011; s_valid = 1'b1;
        for (int k = 0; k < NSAMP; k++) s_data[k*16 +: 16] = 16'h1000 + 16'(k);
        cycle();
        vectors += 2;
        if (dac_data[8*16 +: 64] !== 64'd0) begin
            miscompares++; $display("FAIL dma_ch2_masked got %h expected 0", dac_data[8*16 +: 64]);
        end
        if (dac_data[15*16 +: 16] !== 16'h100F) begin
            miscompares++; $display("FAIL dma_ch3_s3 got %h expected 100f", dac_data[15*16 +: 16]);
        end
        for (int b = 0; b < 40; b++) begin
            s_data = rand_data();
            s_valid = ($urandom_range(3) != 0);
            chan_enable = 4'($urandom);
            cycle();
        end
        s_valid = 1'b1; chan_enable = '1;
    endtask

    task automatic test_underflow();
        dac_mode = 2'd1; s_valid = 1'b1; s_data = rand_data(); status_clear = 1'b1;
        cycle();
        status_clear = 1'b0; s_valid = 1'b0;
        repeat (3) cycle();
        vectors += 2;
        if (status_underflow !== 1'b1) begin miscompares++; $display("FAIL uf_flag got %b expected 1", status_underflow); end
`ifdef DAC_TX_SEQ_UNDERFLOW_CNT_EN
        if (underflow_count !== 16'd3) begin miscompares++; $display("FAIL uf_count3 got %0d expected 3", underflow_count); end
`else
        if (underflow_count !== 16'd0) begin miscompares++; $display("FAIL uf_count_off got %0d expected 0", underflow_count); end
`endif
        status_clear = 1'b1;
        cycle();
        status_clear = 1'b0;
        vectors += 2;
        if (status_underflow !== 1'b1) begin miscompares++; $display("FAIL uf_set_wins got %b expected 1", status_underflow); end
`ifdef DAC_TX_SEQ_UNDERFLOW_CNT_EN
        if (underflow_count !== 16'd1) begin miscompares++; $display("FAIL uf_count_restart got %0d expected 1", underflow_count); end
`else
        if (underflow_count !== 16'd0) begin miscompares++; $display("FAIL uf_count_off2 got %0d expected 0", underflow_count); end
`endif
        s_valid = 1'b1;
        cycle();
    endtask

    task automatic test_ramp();
        int waited;
        dac_enable = 1'b0;
        cycle();
        dac_enable = 1'b1; link_ready = 1'b1; dac_mode = 2'd2; chan_enable = '1; s_valid = 1'b0;
        wait_running("ramp_entry", waited);
        for (int b = 0; b <= 16385; b++) begin
            cycle();
            if (b == 0 || b == 1 || b == 16383 || b == 16384) begin
                vectors++;
                if (dac_data[63:0] !== {16'(b*4 + 3), 16'(b*4 + 2), 16'(b*4 + 1), 16'(b*4)}) begin
                    miscompares++;
                    $display("FAIL ramp_beat%0d got %h expected base %h", b, dac_data[63:0], 16'(b*4));
                end
            end
        end
    endtask

    task automatic test_link_drop();
        int waited;
        dac_mode = 2'd1; s_valid = 1'b1; s_data = rand_data();
        cycle();
        link_ready = 1'b0;
        cycle();
        vectors += 3;
        if (s_ready !== 1'b0)          begin miscompares++; $display("FAIL drop_s_ready got %b expected 0", s_ready); end
        if (dac_running !== 1'b0)      begin miscompares++; $display("FAIL drop_running got %b expected 0", dac_running); end
        if (status_link_lost !== 1'b1) begin miscompares++; $display("FAIL drop_flag got %b expected 1", status_link_lost); end
        link_ready = 1'b1;
        wait_running("relink", waited);
        vectors++;
        if (waited != SETTLE_CYCLES + 1) begin
            miscompares++; $display("FAIL relink_settle got %0d cycles expected %0d", waited, SETTLE_CYCLES + 1);
        end
    endtask

    task automatic test_disable();
        dac_mode = 2'd1; s_valid = 1'b1; s_data = rand_data();
        cycle();
        dac_enable = 1'b0; s_data = rand_data();
        cycle();
        vectors += 2;
        if (s_ready !== 1'b0)     begin miscompares++; $display("FAIL disable_s_ready got %b expected 0", s_ready); end
        if (dac_running !== 1'b0) begin miscompares++; $display("FAIL disable_running got %b expected 0", dac_running); end
        s_data = rand_data();
        repeat (3) cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            dac_enable   = ($urandom_range(99) < 97);
            link_ready   = ($urandom_range(99) < 96);
            dac_mode     = 2'($urandom);
            s_valid      = ($urandom_range(9) < 7);
            s_data       = rand_data();
            status_clear = ($urandom_range(19) == 0);
            if ($urandom_range(15) == 0) chan_enable = 4'($urandom);
            cycle();
        end
        status_clear = 1'b0;
    endtask

    task automatic test_async_reset();
        int waited;
        dac_enable = 1'b1; link_ready = 1'b1; dac_mode = 2'd1; s_valid = 1'b1;
        chan_enable = '1; s_data = rand_data();
        wait_running("pre_reset", waited);
        repeat (3) begin s_data = rand_data(); cycle(); end
        #2;
        dac_rstn = 1'b0;
        #1;
        vectors += 5;
        if (dac_data !== '0)           begin miscompares++; $display("FAIL areset_data got %h expected 0", dac_data); end
        if (s_ready !== 1'b0)          begin miscompares++; $display("FAIL areset_s_ready got %b expected 0", s_ready); end
        if (dac_running !== 1'b0)      begin miscompares++; $display("FAIL areset_running got %b expected 0", dac_running); end
        if (status_underflow !== 1'b0) begin miscompares++; $display("FAIL areset_uf got %b expected 0", status_underflow); end
        if (underflow_count !== 16'd0) begin miscompares++; $display("FAIL areset_cnt got %0d expected 0", underflow_count); end
        idle_inputs();
        #20;
        release_reset();
        repeat (5) cycle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_startup();
        test_dma_mask();
        test_underflow();
        test_ramp();
        test_link_drop();
        test_disable();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_dac_jesd204_tx_sequencer.md
Name: axi_dac_jesd204_tx_sequencer

Overview:
Sequences the DAC sample stream that feeds the JESD204 TX framer/lane-mapping stage. Gates DMA sample data behind link readiness and a settle delay, and sources zeros or a ramp test pattern when required. Applies a per-channel enable mask and reports underflow and link-loss status. Sits between the upstream DMA/FIFO stream and the framer, in the tx_clk (line-rate/40) domain.

Parameters:
NUM_LANES, 8, JESD lanes; sample word width W = NUM_LANES*32
NUM_CHANNELS, 4, converter channels; DPW = 2*NUM_LANES/NUM_CHANNELS samples per channel per beat
SETTLE_CYCLES, 16, cycles held at zero after link_ready before RUN; 0 = enter RUN directly

Ports:
tx_clk  in  1  sequencer clock, tx_clk domain
dac_rstn  in  1  asynchronous active-low reset
dac_enable  in  1  level; 1 = request streaming, 0 = stop
dac_mode  in  2  0 = zeros, 1 = DMA, 2 = ramp, 3 = zeros
chan_enable  in  NUM_CHANNELS  per-channel output mask; 0 forces that channel's samples to 0
link_ready  in  1  JESD TX link layer in DATA phase
s_data  in  W  upstream samples; channel i, sample j at bits [(i*DPW+j)*16 +: 16]
s_valid  in  1  upstream data valid
s_ready  out  1  sequencer accepts s_data
dac_data  out  W  to framer, registered
dac_running  out  1  state == RUN
status_underflow  out  1  sticky underflow flag
status_link_lost  out  1  sticky link drop during RUN
status_clear  in  1  single-cycle pulse; clears both sticky flags
underflow_count  out  16  saturating underflow counter (optional feature)

Behaviour:
- Reset (dac_rstn=0, async): state IDLE, dac_data=0, s_ready=0, dac_running=0, both flags=0, settle counter=0, ramp base=0, underflow_count=0.
- States: IDLE, WAIT_LINK, SETTLE, RUN.
- IDLE: dac_enable=1 -> WAIT_LINK.
- WAIT_LINK: link_ready=1 -> SETTLE, loading counter with SETTLE_CYCLES-1; if SETTLE_CYCLES=0 -> RUN.
- SETTLE: decrement each cycle; at 0 -> RUN.
- RUN: stays while dac_enable=1 and link_ready=1.
- dac_enable=0 in any non-IDLE state -> IDLE next cycle; takes priority over link events.
- link_ready=0 in SETTLE -> WAIT_LINK, no flag.
- link_ready=0 in RUN -> WAIT_LINK; set status_link_lost.
- s_ready = (state==RUN) && (dac_mode==1); derived from registered state only, with no combinational path from s_valid.
- dac_data updates every cycle; latency is 1 cycle from accept (s_valid&&s_ready) to dac_data.
- Outside RUN, dac_data = 0.
- RUN, mode 1: on accept, dac_data = masked s_data.
  - If s_valid=0: dac_data = 0 (no hold of last value).
  - Each such cycle is an underflow: set status_underflow; underflow_count +1, saturating at 0xFFFF.
- RUN, mode 2: sample (i,j) = base + j, mod 2^16; base += DPW each RUN cycle, wrapping.
  - base resets to 0 on every entry to RUN.
  - Mask applied. No underflow in this mode.
- RUN, mode 0/3: dac_data = 0; no underflow.
- dac_mode changes take effect on the next cycle; base is not reset by a mode change.
- Sticky flags: set condition and status_clear in the same cycle -> flag stays 1. status_clear also zeroes underflow_count, with the same set-wins rule (count -> 1).
- Beats are never dropped: s_data is consumed only when s_ready=1.

Optional Feature:
DAC_TX_SEQ_UNDERFLOW_CNT_EN
- Defined: 16-bit saturating underflow_count implemented as described above.
- Undefined: underflow_count tied to 16'd0, no counter logic; status_underflow unaffected.

Test Plan:
- Reset then dac_enable=1, link_ready=1 at cycle 5, SETTLE_CYCLES=16 -> dac_running rises at cycle 5+16+1 with ±0 tolerance as specified; dac_data=0 throughout.
- RUN, mode 1, NUM_LANES=8, NUM_CHANNELS=4, chan_enable=4'b1011, s_data pattern 16'h1000+idx -> dac_data equals the input 1 cycle later, with channel 2 samples (idx 8..11) = 0.
- RUN, mode 1, s_valid low 3 cycles -> dac_data=0 for those 3 cycles, status_underflow=1, underflow_count=3; status_clear coincident with a 4th underflow -> flag=1, count=1.
- RUN, mode 2, DPW=4 -> beat 0 channel 0 samples {0,1,2,3}, beat 1 {4,5,6,7}; base 16'hFFFC + 4 wraps to 0.
- link_ready drop in RUN -> next cycle s_ready=0, dac_running=0, status_link_lost=1; relink -> SETTLE again.
- dac_enable=0 mid-RUN with s_valid=1 -> IDLE next cycle, s_ready=0, no further beats consumed; async reset mid-RUN -> all outputs 0 immediately.
